// File: rtl/axi_pkg.sv
// Shared AXI response/size codes, FSM state types and the request legality check
// used by both the write and read channels of the SRAM slave.
package axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    localparam logic [2:0] SIZE_1B = 3'd0;
    localparam logic [2:0] SIZE_2B = 3'd1;
    localparam logic [2:0] SIZE_4B = 3'd2;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_WAIT = 2'd2,
        W_RESP = 2'd3
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rstate_e;

    // Decode error wins over slave error: an unmapped address is never inspected further.
    function automatic resp_e addr_resp(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] span,
                                        input logic [7:0]  len,
                                        input logic [2:0]  size);
        logic misalign;
        misalign = ((size == SIZE_2B) && addr[0]) ||
                   ((size == SIZE_4B) && (addr[1:0] != 2'b00));
        if ((addr < base) || ((addr - base) >= span))
            return RESP_DECERR;
        if ((len != 8'd0) || (size > SIZE_4B) || misalign)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// Word-organised SRAM with per-byte write enables and one registered read port.
// Read data updates only on i_rd_en and holds otherwise; contents survive reset.
module axi_sram_mem
    import axi_pkg::*;
#(
    parameter int WORDS = 4096,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_addr,
    input  logic [3:0]       i_wr_strb,
    input  logic [31:0]      i_wr_data,
    input  logic             i_rd_en,
    input  logic [IDX_W-1:0] i_rd_addr,
    output logic [31:0]      o_rd_data
);

    logic [31:0] r_mem [WORDS];
    logic [31:0] r_rd_data;

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wr_strb[b])
                    r_mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_rd_data <= '0;
        else if (i_rd_en)
            r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI4 slave over a byte-writable SRAM; B/R valid LATENCY cycles after W/AR.
// Independent write and read FSMs; responses hold until bready/rready.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter int          MEM_WORDS = 4096,
    parameter int          LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_slave_awready,
    input  logic        io_slave_awvalid,
    input  logic [31:0] io_slave_awaddr,
    input  logic [3:0]  io_slave_awid,
    input  logic [7:0]  io_slave_awlen,
    input  logic [2:0]  io_slave_awsize,
    input  logic [1:0]  io_slave_awburst,
    output logic        io_slave_wready,
    input  logic        io_slave_wvalid,
    input  logic [31:0] io_slave_wdata,
    input  logic [3:0]  io_slave_wstrb,
    input  logic        io_slave_wlast,
    input  logic        io_slave_bready,
    output logic        io_slave_bvalid,
    output logic [1:0]  io_slave_bresp,
    output logic [3:0]  io_slave_bid,
    output logic        io_slave_arready,
    input  logic        io_slave_arvalid,
    input  logic [31:0] io_slave_araddr,
    input  logic [3:0]  io_slave_arid,
    input  logic [7:0]  io_slave_arlen,
    input  logic [2:0]  io_slave_arsize,
    input  logic [1:0]  io_slave_arburst,
    input  logic        io_slave_rready,
    output logic        io_slave_rvalid,
    output logic [1:0]  io_slave_rresp,
    output logic [31:0] io_slave_rdata,
    output logic        io_slave_rlast,
    output logic [3:0]  io_slave_rid
);

    localparam int          IDX_W    = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN     = 32'(4 * MEM_WORDS);
    localparam logic [3:0]  LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam bit          NO_WAIT  = (LATENCY == 0);

    // ---------------- write channel ----------------
    wstate_e     r_wstate, w_wstate_nxt;
    logic [31:0] r_awaddr;
    logic [3:0]  r_awid;
    logic [7:0]  r_awlen;
    logic [2:0]  r_awsize;
    logic [3:0]  r_wcnt;
    resp_e       r_bresp;
    logic [3:0]  r_bid;

    logic        w_aw_hs, w_w_hs, w_mem_we;
    resp_e       w_aw_resp, w_w_resp;
    logic [31:0] w_aw_off;

    assign w_aw_hs   = io_slave_awvalid & io_slave_awready;
    assign w_w_hs    = io_slave_wvalid & io_slave_wready;
    assign w_aw_resp = addr_resp(r_awaddr, ADDR_BASE, SPAN, r_awlen, r_awsize);
    assign w_w_resp  = ((w_aw_resp == RESP_OKAY) && !io_slave_wlast) ? RESP_SLVERR : w_aw_resp;
    assign w_mem_we  = w_w_hs && (w_w_resp == RESP_OKAY);
    assign w_aw_off  = r_awaddr - ADDR_BASE;

    always_comb begin
        w_wstate_nxt     = r_wstate;
        io_slave_awready = 1'b0;
        io_slave_wready  = 1'b0;
        io_slave_bvalid  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                io_slave_awready = ~reset;
                if (io_slave_awvalid)
                    w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                io_slave_wready = ~reset;
                if (io_slave_wvalid)
                    w_wstate_nxt = NO_WAIT ? W_RESP : W_WAIT;
            end
            W_WAIT: begin
                if (r_wcnt == 4'd0)
                    w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                io_slave_bvalid = ~reset;
                if (io_slave_bready)
                    w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wstate <= W_IDLE;
            r_awaddr <= '0;
            r_awid   <= '0;
            r_awlen  <= '0;
            r_awsize <= '0;
            r_wcnt   <= '0;
            r_bresp  <= RESP_OKAY;
            r_bid    <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_aw_hs) begin
                r_awaddr <= io_slave_awaddr;
                r_awid   <= io_slave_awid;
                r_awlen  <= io_slave_awlen;
                r_awsize <= io_slave_awsize;
                r_bid    <= io_slave_awid;
            end
            if (w_w_hs) begin
                r_bresp <= w_w_resp;
                r_wcnt  <= LAT_INIT;
            end else if ((r_wstate == W_WAIT) && (r_wcnt != 4'd0)) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
        end
    end

    assign io_slave_bresp = r_bresp;
    assign io_slave_bid   = r_bid;

    // ---------------- read channel ----------------
    rstate_e     r_rstate, w_rstate_nxt;
    logic [31:0] r_araddr;
    logic [3:0]  r_rcnt;
    resp_e       r_rresp;
    logic [3:0]  r_rid;

    logic        w_ar_hs, w_rd_en;
    resp_e       w_ar_resp;
    logic [31:0] w_rd_src, w_ar_off, w_mem_rdata;

    assign w_ar_hs   = io_slave_arvalid & io_slave_arready;
    assign w_ar_resp = addr_resp(io_slave_araddr, ADDR_BASE, SPAN, io_slave_arlen, io_slave_arsize);
    // The array is sampled on the edge that enters R_DATA, straight from the bus when there is no wait.
    assign w_rd_en   = ((r_rstate == R_IDLE) && w_ar_hs && NO_WAIT) ||
                       ((r_rstate == R_WAIT) && (r_rcnt == 4'd0));
    assign w_rd_src  = (r_rstate == R_IDLE) ? io_slave_araddr : r_araddr;
    assign w_ar_off  = w_rd_src - ADDR_BASE;

    always_comb begin
        w_rstate_nxt     = r_rstate;
        io_slave_arready = 1'b0;
        io_slave_rvalid  = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                io_slave_arready = ~reset;
                if (io_slave_arvalid)
                    w_rstate_nxt = NO_WAIT ? R_DATA : R_WAIT;
            end
            R_WAIT: begin
                if (r_rcnt == 4'd0)
                    w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                io_slave_rvalid = ~reset;
                if (io_slave_rready)
                    w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rstate <= R_IDLE;
            r_araddr <= '0;
            r_rcnt   <= '0;
            r_rresp  <= RESP_OKAY;
            r_rid    <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_hs) begin
                r_araddr <= io_slave_araddr;
                r_rresp  <= w_ar_resp;
                r_rid    <= io_slave_arid;
                r_rcnt   <= LAT_INIT;
            end else if ((r_rstate == R_WAIT) && (r_rcnt != 4'd0)) begin
                r_rcnt <= r_rcnt - 4'd1;
            end
        end
    end

    assign io_slave_rresp = r_rresp;
    assign io_slave_rid   = r_rid;
    assign io_slave_rlast = io_slave_rvalid;
    assign io_slave_rdata = (r_rresp == RESP_OKAY) ? w_mem_rdata : 32'd0;

    axi_sram_mem #(
        .WORDS (MEM_WORDS),
        .IDX_W (IDX_W)
    ) u_mem (
        .clock     (clock),
        .reset     (reset),
        .i_wr_en   (w_mem_we),
        .i_wr_addr (w_aw_off[IDX_W+1:2]),
        .i_wr_strb (io_slave_wstrb),
        .i_wr_data (io_slave_wdata),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_ar_off[IDX_W+1:2]),
        .o_rd_data (w_mem_rdata)
    );

    logic w_unused;
    assign w_unused = &{1'b0, io_slave_awburst, io_slave_arburst,
                        w_aw_off[31:IDX_W+2], w_aw_off[1:0],
                        w_ar_off[31:IDX_W+2], w_ar_off[1:0], r_awid};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: expected B/R beats queued at issue, checked on arrival.
module tb_axi_sram_slave;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 4096;
    localparam int          LAT   = 2;

    typedef struct {
        logic [1:0]  resp;
        logic [3:0]  id;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        awready, awvalid, wready, wvalid, wlast, bready, bvalid;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  awid, wstrb, bid, arid, rid;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        arready, arvalid, rready, rvalid, rlast;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    exp_t        b_q[$];
    exp_t        r_q[$];
    logic [31:0] model [int];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    axi_sram_slave #(.ADDR_BASE(BASE), .MEM_WORDS(WORDS), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .io_slave_awready(awready), .io_slave_awvalid(awvalid), .io_slave_awaddr(awaddr),
        .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize),
        .io_slave_awburst(awburst),
        .io_slave_wready(wready), .io_slave_wvalid(wvalid), .io_slave_wdata(wdata),
        .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
        .io_slave_bready(bready), .io_slave_bvalid(bvalid), .io_slave_bresp(bresp),
        .io_slave_bid(bid),
        .io_slave_arready(arready), .io_slave_arvalid(arvalid), .io_slave_araddr(araddr),
        .io_slave_arid(arid), .io_slave_arlen(arlen), .io_slave_arsize(arsize),
        .io_slave_arburst(arburst),
        .io_slave_rready(rready), .io_slave_rvalid(rvalid), .io_slave_rresp(rresp),
        .io_slave_rdata(rdata), .io_slave_rlast(rlast), .io_slave_rid(rid)
    );

    function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic last);
        logic mis;
        mis = (size == 3'd1 && a[0]) || (size == 3'd2 && a[1:0] != 2'b00);
        if (a < BASE || a >= BASE + 32'(4 * WORDS)) return 2'b11;
        if (len != 8'd0 || size > 3'd2 || mis || !last) return 2'b10;
        return 2'b00;
    endfunction

    task automatic wait_ready(input string nm, input logic which_aw, input logic which_w,
                              input logic which_ar);
        int n = 0;
        while (n < 30 && !((which_aw && awready === 1'b1) || (which_w && wready === 1'b1) ||
                           (which_ar && arready === 1'b1))) begin
            @(negedge clock);
            n++;
        end
        if (n >= 30) begin
            checks++; errors++;
            $display("FAIL %s_timeout: ready never seen", nm);
        end
    endtask

    task automatic collect_b(input string nm);
        exp_t e;
        int n = 0;
        bready = 1'b1;
        @(negedge clock);
        while (bvalid !== 1'b1 && n < 40) begin @(negedge clock); n++; end
        e = b_q.pop_front();
        checks++;
        if (bvalid !== 1'b1) begin
            errors++; $display("FAIL %s_bvalid: got %b want 1", nm, bvalid);
        end else begin
            checks += 2;
            if (bresp !== e.resp) begin errors++; $display("FAIL %s_bresp: got %b want %b", nm, bresp, e.resp); end
            if (bid !== e.id) begin errors++; $display("FAIL %s_bid: got %0d want %0d", nm, bid, e.id); end
        end
        @(posedge clock); #1 bready = 1'b0;
    endtask

    task automatic collect_r(input string nm);
        exp_t e;
        int n = 0;
        rready = 1'b1;
        @(negedge clock);
        while (rvalid !== 1'b1 && n < 40) begin @(negedge clock); n++; end
        e = r_q.pop_front();
        checks++;
        if (rvalid !== 1'b1) begin
            errors++; $display("FAIL %s_rvalid: got %b want 1", nm, rvalid);
        end else begin
            checks += 4;
            if (rdata !== e.data) begin errors++; $display("FAIL %s_rdata: got %h want %h", nm, rdata, e.data); end
            if (rresp !== e.resp) begin errors++; $display("FAIL %s_rresp: got %b want %b", nm, rresp, e.resp); end
            if (rid !== e.id) begin errors++; $display("FAIL %s_rid: got %0d want %0d", nm, rid, e.id); end
            if (rlast !== 1'b1) begin errors++; $display("FAIL %s_rlast: got %b want 1", nm, rlast); end
        end
        @(posedge clock); #1 rready = 1'b0;
    endtask

    task automatic axi_write(input string nm, input logic [31:0] a, input logic [3:0] id,
                             input logic [31:0] d, input logic [3:0] strb,
                             input logic [2:0] size, input logic [7:0] len, input logic last);
        exp_t e;
        int   idx;
        e.resp = exp_resp(a, len, size, last);
        e.id   = id;
        e.data = 32'd0;
        b_q.push_back(e);
        if (e.resp == 2'b00) begin
            idx = int'((a - BASE) >> 2);
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][8*b +: 8] = d[8*b +: 8];
        end
        @(negedge clock);
        awvalid = 1'b1; awaddr = a; awid = id; awlen = len; awsize = size; awburst = 2'b01;
        wait_ready({nm, "_aw"}, 1'b1, 1'b0, 1'b0);
        @(posedge clock); #1 awvalid = 1'b0;
        @(negedge clock);
        wvalid = 1'b1; wdata = d; wstrb = strb; wlast = last;
        wait_ready({nm, "_w"}, 1'b0, 1'b1, 1'b0);
        @(posedge clock); #1 wvalid = 1'b0;
        collect_b(nm);
    endtask

    task automatic push_read(input logic [31:0] a, input logic [3:0] id,
                             input logic [2:0] size, input logic [7:0] len);
        exp_t e;
        e.resp = exp_resp(a, len, size, 1'b1);
        e.id   = id;
        e.data = (e.resp == 2'b00) ? model[int'((a - BASE) >> 2)] : 32'd0;
        r_q.push_back(e);
    endtask

    task automatic axi_read(input string nm, input logic [31:0] a, input logic [3:0] id,
                            input logic [2:0] size, input logic [7:0] len);
        push_read(a, id, size, len);
        @(negedge clock);
        arvalid = 1'b1; araddr = a; arid = id; arlen = len; arsize = size; arburst = 2'b01;
        wait_ready({nm, "_ar"}, 1'b0, 1'b0, 1'b1);
        @(posedge clock); #1 arvalid = 1'b0;
        collect_r(nm);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            errors++; $display("FAIL rst_handshakes: got %b want 00000", {awready, wready, bvalid, arready, rvalid});
        end
        checks++;
        if ({bresp, bid, rresp, rid, rdata} !== 44'd0) begin
            errors++; $display("FAIL rst_payload: got %h want 0", {bresp, bid, rresp, rid, rdata});
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({awready, arready, bvalid, rvalid} !== 4'b1100) begin
            errors++; $display("FAIL rst_release: got %b want 1100", {awready, arready, bvalid, rvalid});
        end
    endtask

    task automatic test_write_read();
        axi_write("wr_basic", 32'h8000_0010, 4'd3, 32'hDEAD_BEEF, 4'hF, 3'd2, 8'd0, 1'b1);
        axi_read("rd_basic", 32'h8000_0010, 4'd5, 3'd2, 8'd0);
    endtask

    task automatic test_strobe();
        axi_write("wr_strb1", 32'h8000_0010, 4'd1, 32'h0000_00AB, 4'h1, 3'd2, 8'd0, 1'b1);
        axi_read("rd_strb1", 32'h8000_0010, 4'd2, 3'd2, 8'd0);
        axi_write("wr_strb0", 32'h8000_0010, 4'd4, 32'h1111_1111, 4'h0, 3'd2, 8'd0, 1'b1);
        axi_read("rd_strb0", 32'h8000_0010, 4'd6, 3'd2, 8'd0);
    endtask

    task automatic test_errors();
        axi_write("wr_base", 32'h8000_0000, 4'd1, 32'h1234_5678, 4'hF, 3'd2, 8'd0, 1'b1);
        axi_read("rd_decerr", 32'h1000_0000, 4'd7, 3'd2, 8'd0);
        axi_write("wr_misal", 32'h8000_0002, 4'd8, 32'hFFFF_FFFF, 4'hF, 3'd2, 8'd0, 1'b1);
        axi_write("wr_len1", 32'h8000_0000, 4'd9, 32'hAAAA_AAAA, 4'hF, 3'd2, 8'd1, 1'b1);
        axi_write("wr_nolast", 32'h8000_0000, 4'd10, 32'hBBBB_BBBB, 4'hF, 3'd2, 8'd0, 1'b0);
        axi_write("wr_size3", 32'h8000_0000, 4'd11, 32'hCCCC_CCCC, 4'hF, 3'd3, 8'd0, 1'b1);
        axi_read("rd_unchanged", 32'h8000_0000, 4'd12, 3'd2, 8'd0);
        axi_write("wr_top", 32'h8000_3FFC, 4'd13, 32'hCAFE_F00D, 4'hF, 3'd2, 8'd0, 1'b1);
        axi_read("rd_top", 32'h8000_3FFC, 4'd14, 3'd2, 8'd0);
        axi_read("rd_past_top", 32'h8000_4000, 4'd15, 3'd2, 8'd0);
        axi_read("rd_below", 32'h7FFF_FFFC, 4'd0, 3'd2, 8'd0);
        axi_read("rd_half_ok", 32'h8000_0002, 4'd1, 3'd1, 8'd0);
        axi_read("rd_half_mis", 32'h8000_0001, 4'd2, 3'd1, 8'd0);
        axi_read("rd_len3", 32'h8000_0000, 4'd3, 3'd2, 8'd3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [6];
        for (int i = 0; i < 6; i++) begin
            addrs[i] = BASE + 32'($urandom_range(64, 4095)) * 32'd4;
            axi_write("b2b_wr", addrs[i], 4'(i), $urandom, 4'hF, 3'd2, 8'd0, 1'b1);
        end
        for (int i = 0; i < 6; i++)
            axi_read("b2b_rd", addrs[i], 4'(i + 8), 3'd2, 8'd0);
    endtask

    task automatic test_latency_stall();
        exp_t e;
        int   h, n;
        push_read(32'h8000_0010, 4'd5, 3'd2, 8'd0);
        e = r_q.pop_front();
        rready = 1'b0;
        @(negedge clock);
        arvalid = 1'b1; araddr = 32'h8000_0010; arid = 4'd5; arlen = 8'd0; arsize = 3'd2;
        wait_ready("lat_ar", 1'b0, 1'b0, 1'b1);
        @(posedge clock); #1 arvalid = 1'b0; h = cyc;
        n = 0;
        @(negedge clock);
        while (rvalid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        checks++;
        if (cyc - h !== LAT) begin
            errors++; $display("FAIL lat_cycles: got %0d want %0d", cyc - h, LAT);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({rvalid, rdata, rid, rresp} !== {1'b1, e.data, e.id, e.resp}) begin
                errors++; $display("FAIL lat_stall%0d: got %b/%h/%0d/%b want 1/%h/%0d/%b",
                                   k, rvalid, rdata, rid, rresp, e.data, e.id, e.resp);
            end
            @(negedge clock);
        end
        rready = 1'b1;
        @(posedge clock); #1 rready = 1'b0;
        @(negedge clock);
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL lat_release: got %b want 0", rvalid); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        @(negedge clock);
        awvalid = 1'b1; awaddr = 32'h8000_0020; awid = 4'd7; awlen = 8'd0; awsize = 3'd2;
        wait_ready("mid_aw", 1'b1, 1'b0, 1'b0);
        @(posedge clock); #1 awvalid = 1'b0;
        @(negedge clock);
        wvalid = 1'b1; wdata = 32'h5555_AAAA; wstrb = 4'hF; wlast = 1'b1;
        arvalid = 1'b1; araddr = 32'h8000_0010; arid = 4'd9; arlen = 8'd0; arsize = 3'd2;
        model[8] = 32'h5555_AAAA;
        @(posedge clock); #1 wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({awready, arready, bvalid, rvalid, rdata, rid, bid} !== 44'd0) begin
            errors++; $display("FAIL mid_in_reset: got %h want 0", {awready, arready, bvalid, rvalid, rdata, rid, bid});
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({awready, arready} !== 2'b11) begin
            errors++; $display("FAIL mid_ready_after: got %b want 11", {awready, arready});
        end
        for (int k = 0; k < 8; k++) begin
            if (bvalid !== 1'b0 || rvalid !== 1'b0) bad++;
            @(negedge clock);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL mid_stale_valid: got %0d cycles want 0", bad); end
        axi_read("mid_persist", 32'h8000_0010, 4'd3, 3'd2, 8'd0);
    endtask

    initial begin
        {awvalid, wvalid, bready, arvalid, rready, wlast} = '0;
        {awaddr, wdata, araddr} = '0;
        {awid, wstrb, arid, awlen, arlen, awsize, arsize, awburst, arburst} = '0;
        test_reset();
        test_write_read();
        test_strobe();
        test_errors();
        test_back_to_back();
        test_latency_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave
Interface
REQ-001 ADDR_BASE, 32'h8000_0000, byte address of memory word 0.
REQ-002 MEM_WORDS, 4096, depth of 32-bit memory array (power of two).
REQ-003 LATENCY, 2, extra wait cycles before bvalid/rvalid (0..15).
REQ-004 clock  input  1  clock, rising-edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 io_slave_awready  output  1  write address accepted.
REQ-007 io_slave_awvalid  input  1  write address valid.
REQ-008 io_slave_awaddr  input  32  write byte address.
REQ-009 io_slave_awid  input  4  write transaction ID.
REQ-010 io_slave_awlen  input  8  burst length-1; only 0 supported.
REQ-011 io_slave_awsize  input  3  bytes per beat, log2.
REQ-012 io_slave_awburst  input  2  burst type; ignored.
REQ-013 io_slave_wready  output  1  write data accepted.
REQ-014 io_slave_wvalid  input  1  write data valid.
REQ-015 io_slave_wdata  input  32  write data, lane-aligned.
REQ-016 io_slave_wstrb  input  4  byte enables.
REQ-017 io_slave_wlast  input  1  last beat.
REQ-018 io_slave_bready  input  1  master accepts response.
REQ-019 io_slave_bvalid  output  1  write response valid.
REQ-020 io_slave_bresp  output  2  write response code.
REQ-021 io_slave_bid  output  4  echoed awid.
REQ-022 io_slave_arready  output  1  read address accepted.
REQ-023 io_slave_arvalid  input  1  read address valid.
REQ-024 io_slave_araddr  input  32  read byte address.
REQ-025 io_slave_arid  input  4  read transaction ID.
REQ-026 io_slave_arlen  input  8  burst length-1; only 0 supported.
REQ-027 io_slave_arsize  input  3  bytes per beat, log2.
REQ-028 io_slave_arburst  input  2  burst type; ignored.
REQ-029 io_slave_rready  input  1  master accepts read data.
REQ-030 io_slave_rvalid  output  1  read data valid.
REQ-031 io_slave_rresp  output  2  read response code.
REQ-032 io_slave_rdata  output  32  full aligned word at araddr.
REQ-033 io_slave_rlast  output  1  equals rvalid (single beat).
REQ-034 io_slave_rid  output  4  echoed arid.
Function
REQ-035 Write FSM SHALL use states W_IDLE (awready=1) -> W_DATA on AW handshake (latch awaddr/awid/awlen/awsize; wready=1) -> W_WAIT on W handshake (count LATENCY cycles) -> W_RESP (bvalid=1) -> W_IDLE on bvalid&bready; LATENCY=0 skips W_WAIT, so bvalid rises the cycle after W handshake.
REQ-036 Read FSM SHALL use states R_IDLE (arready=1) -> R_WAIT on AR handshake (latch araddr/arid/arlen/arsize) -> R_DATA after LATENCY cycles -> R_IDLE on rvalid&rready; AR handshake at cycle t gives rvalid at t+1+LATENCY.
REQ-037 Response codes: address outside [ADDR_BASE, ADDR_BASE+4*MEM_WORDS) SHALL give DECERR 2'b11; awlen/arlen!=0, size>2, address misaligned for size, or wlast=0 SHALL give SLVERR 2'b10; otherwise OKAY 2'b00; on any error, no memory write and rdata=0.
REQ-038 On OKAY W handshake, memory word (awaddr-ADDR_BASE)>>2 SHALL be updated only in byte lanes with wstrb set, in that clock edge; wstrb=0 writes nothing and returns OKAY.
REQ-039 rdata SHALL be registered from memory on entry to R_DATA, so a write whose W handshake precedes that edge is visible; the write and read FSMs operate independently and concurrently.
REQ-040 bvalid/bresp/bid and rvalid/rdata/rresp/rid/rlast SHALL stay stable while valid and not yet accepted; W beats arriving before AW SHALL wait (wready=0 in W_IDLE).
Reset
REQ-041 Under reset, both FSMs SHALL go to IDLE, all valid/ready outputs and bresp/bid/rresp/rid/rdata 0; outstanding transactions are dropped mid-operation; memory contents are preserved; awready/arready SHALL be 1 in the first cycle after reset deasserts.
Structure
REQ-042 Package axi_pkg SHALL hold resp codes (OKAY/SLVERR/DECERR), size codes, and FSM state enums; sub-module axi_sram_mem (byte-lane-writable array, 1 write port, 1 registered read port) holds the storage.
Verification
REQ-043 AW 0x8000_0010 id 3, W 0xDEADBEEF strb 0xF -> bresp 00, bid 3; AR same address id 5 -> rdata 0xDEADBEEF, rresp 00, rid 5, rlast 1.
REQ-044 Then W 0x0000_00AB strb 0x1 to 0x8000_0010 -> a subsequent read returns 0xDEADBEAB.
REQ-045 AR 0x1000_0000 -> rresp 11, rdata 0; AW 0x8000_0002 size 2 -> bresp 10, memory unchanged.
REQ-046 LATENCY=2, AR handshake at cycle t -> rvalid at t+3; rready held low 5 cycles -> rvalid/rdata/rid stable throughout.
REQ-047 Reset asserted in R_WAIT and W_WAIT -> no rvalid/bvalid afterward, arready=awready=1 next cycle, previously written 0xDEADBEAB still readable.
